attitude_integrator: RTL



---
 rtl/attitude_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/attitude_integrator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/attitude_pkg.sv
// Shared widths, signed range helpers and sweep FSM encoding
// for the multi-axis attitude integrator.
package attitude_pkg;

  localparam int DEF_N_AXES   = 3;
  localparam int DEF_RATE_W   = 8;
  localparam int DEF_ANGLE_W  = 16;
  localparam int DEF_TICK_DIV = 1000000;
  localparam int DEF_SATURATE = 1;
  localparam int DEF_LED_W    = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic signed [63:0] smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV clocks,
// first tick DIV cycles after reset release.
module tick_prescaler #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/attitude_integrator.sv
// Multi-axis rate-to-angle integrator: one shared adder walks
// the axes once per tick, wrapping or saturating each angle.
module attitude_integrator
  import attitude_pkg::*;
#(
  parameter int N_AXES   = DEF_N_AXES,
  parameter int RATE_W   = DEF_RATE_W,
  parameter int ANGLE_W  = DEF_ANGLE_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SATURATE = DEF_SATURATE,
  parameter int LED_W    = DEF_LED_W
) (
  input  logic                        clk,
  input  logic                        reset_p,
  input  logic [N_AXES*RATE_W-1:0]    rate_in,
  input  logic                        rate_valid,
  input  logic [N_AXES-1:0]           zero_req,
  input  logic [2:0]                  led_sel,
  output logic [N_AXES*ANGLE_W-1:0]   angle_out,
  output logic                        angle_valid,
  output logic [N_AXES-1:0]           ovf,
  output logic                        busy,
  output logic [LED_W-1:0]            led
);

  localparam int KW = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N_AXES - 1);
  localparam logic signed [ANGLE_W-1:0] AMAX = ANGLE_W'(smax(ANGLE_W));
  localparam logic signed [ANGLE_W-1:0] AMIN = ANGLE_W'(smin(ANGLE_W));

  logic tick;

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (tick)
  );

  logic signed [RATE_W-1:0]  rate_q [N_AXES];
  logic signed [RATE_W-1:0]  snap   [N_AXES];
  logic signed [ANGLE_W-1:0] angle  [N_AXES];
  logic [1:0]                state;
  logic [KW-1:0]             k;

  logic signed [ANGLE_W:0]   sum;
  logic signed [ANGLE_W-1:0] next_angle;
  logic                      over;
  logic signed [ANGLE_W-1:0] sel_angle;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < N_AXES; i++) rate_q[i] <= '0;
    end else if (rate_valid) begin
      for (int i = 0; i < N_AXES; i++)
        rate_q[i] <= rate_in[i*RATE_W +: RATE_W];
    end
  end

  // Add one bit of headroom; differing top bits mean overflow.
  always_comb begin
    sum  = (ANGLE_W+1)'(angle[k]) + (ANGLE_W+1)'(snap[k]);
    over = sum[ANGLE_W] ^ sum[ANGLE_W-1];
    next_angle = sum[ANGLE_W-1:0];
    if (over && (SATURATE != 0))
      next_angle = sum[ANGLE_W] ? AMIN : AMAX;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state       <= S_IDLE;
      k           <= '0;
      busy        <= 1'b0;
      angle_valid <= 1'b0;
      for (int i = 0; i < N_AXES; i++) snap[i] <= '0;
    end else begin
      angle_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tick) begin
            for (int i = 0; i < N_AXES; i++) snap[i] <= rate_q[i];
            k     <= '0;
            busy  <= 1'b1;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (k == KLAST) begin
            k           <= '0;
            busy        <= 1'b0;
            angle_valid <= 1'b1;
            state       <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A clear request outranks the sweep write to the same axis.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < N_AXES; i++) angle[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < N_AXES; i++) begin
        if (zero_req[i]) begin
          angle[i] <= '0;
          ovf[i]   <= 1'b0;
        end else if (state == S_ACC && k == KW'(i)) begin
          angle[i] <= next_angle;
          if (over) ovf[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_angle = '0;
    for (int i = 0; i < N_AXES; i++)
      if (led_sel == 3'(i)) sel_angle = angle[i];
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      led <= '0;
    else
      led <= sel_angle[ANGLE_W-1 -: LED_W];
  end

  always_comb begin
    angle_out = '0;
    for (int i = 0; i < N_AXES; i++)
      angle_out[i*ANGLE_W +: ANGLE_W] = angle[i];
  end

endmodule
